// File: rtl/nco_voice_scheduler_if.sv
// Bundle of control, wavetable and output signals around the voice scheduler.
// slave = scheduler side, master = surrounding control/wavetable/output side.
interface nco_voice_scheduler_if #(
    parameter int VOICES           = 8,
    parameter int FREQ_BITS        = 16,
    parameter int AMP_BITS         = 16,
    parameter int PHASE_INDEX_BITS = 26
);
    localparam int VW = $clog2(VOICES);

    logic                        sample_tick;
    logic                        cfg_we;
    logic [VW-1:0]               cfg_voice;
    logic [FREQ_BITS-1:0]        cfg_freq;
    logic                        cfg_gate;
    logic [PHASE_INDEX_BITS-1:0] wt_phase;
    logic signed [AMP_BITS-1:0]  wt_q;
    logic                        out_valid;
    logic [VW-1:0]               out_voice;
    logic signed [AMP_BITS-1:0]  out_amp;
    logic                        mix_valid;
    logic signed [AMP_BITS-1:0]  mix;
    logic                        busy;
    logic                        overrun;

    modport slave (
        input  sample_tick, cfg_we, cfg_voice, cfg_freq, cfg_gate, wt_q,
        output wt_phase, out_valid, out_voice, out_amp, mix_valid, mix, busy, overrun
    );

    modport master (
        output sample_tick, cfg_we, cfg_voice, cfg_freq, cfg_gate, wt_q,
        input  wt_phase, out_valid, out_voice, out_amp, mix_valid, mix, busy, overrun
    );
endinterface

// File: rtl/nco_voice_scheduler.sv
// Time-division NCO sequencer: one shared wavetable serves VOICES voices per sample tick,
// producing per-voice samples and a saturated mix.
module nco_voice_scheduler #(
    parameter int VOICES            = 8,
    parameter int SAMPLE_RATE       = 192_000,
    parameter int WT_LATENCY        = 1,
    parameter int FREQ_BITS         = 16,
    parameter int AMP_BITS          = 16,
    parameter int WAVETABLE_N       = 10,
    parameter int C_FRACTIONAL_BITS = 16,
    parameter int PAC_BITS          = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    nco_voice_scheduler_if.slave bus
);
    localparam int VW               = $clog2(VOICES);
    localparam int PHASE_INDEX_BITS = WAVETABLE_N + C_FRACTIONAL_BITS;
    localparam int ACC_BITS         = AMP_BITS + VW;
    localparam int DW               = (WT_LATENCY > 1) ? $clog2(WT_LATENCY) : 1;
    // Phase increment per Hz: 2**(N+F) / SAMPLE_RATE, truncated toward zero.
    localparam longint C_FULL = (longint'(1) << PHASE_INDEX_BITS) / longint'(SAMPLE_RATE);
    localparam logic [PAC_BITS-1:0] C = PAC_BITS'(C_FULL);
    localparam logic signed [AMP_BITS-1:0] AMP_MAX = {1'b0, {(AMP_BITS-1){1'b1}}};
    localparam logic signed [AMP_BITS-1:0] AMP_MIN = {1'b1, {(AMP_BITS-1){1'b0}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MAX = {{(VW+1){1'b0}}, {(AMP_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN = {{(VW+1){1'b1}}, {(AMP_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t                      state_reg, state_next;
    logic [VW-1:0]               slot_reg, slot_next;
    logic [DW-1:0]               drain_reg, drain_next;
    logic                        accept, slot_active, done;
    logic                        busy_reg, overrun_reg, mix_valid_reg;
    logic signed [AMP_BITS-1:0]  mix_reg;
    logic signed [ACC_BITS-1:0]  acc_reg, amp_ext, sum;
    logic signed [AMP_BITS-1:0]  amp, mix_sat;

    logic [FREQ_BITS-1:0]        freq_reg [VOICES];
    logic [PHASE_INDEX_BITS-1:0] phase_reg [VOICES];
    logic [VOICES-1:0]           gate_reg;
    logic [VOICES-1:0]           cfg_hit, slot_hit, gate_rise;
    logic [PHASE_INDEX_BITS-1:0] inc;
    logic [PHASE_INDEX_BITS-1:0] wt_phase_reg;

    logic [WT_LATENCY:0]         pipe_valid_reg, pipe_gate_reg;
    logic [VW-1:0]               pipe_voice_reg [WT_LATENCY+1];

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            assign cfg_hit[gi]   = bus.cfg_we && (bus.cfg_voice == VW'(gi));
            assign slot_hit[gi]  = slot_active && (slot_reg == VW'(gi));
            assign gate_rise[gi] = cfg_hit[gi] && bus.cfg_gate && !gate_reg[gi];
        end
    endgenerate

    assign inc = PHASE_INDEX_BITS'(freq_reg[slot_reg]) * PHASE_INDEX_BITS'(C);

    always_comb begin
        state_next  = state_reg;
        slot_next   = slot_reg;
        drain_next  = drain_reg;
        accept      = 1'b0;
        slot_active = 1'b0;
        done        = 1'b0;
        case (state_reg)
            IDLE: begin
                // busy_reg still high here means this is the mix_valid cycle.
                if (bus.sample_tick && !busy_reg) begin
                    accept     = 1'b1;
                    state_next = SWEEP;
                    slot_next  = '0;
                end
            end
            SWEEP: begin
                slot_active = 1'b1;
                slot_next   = slot_reg + VW'(1);
                if (slot_reg == VW'(VOICES - 1)) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end
            end
            DRAIN: begin
                if (drain_reg == DW'(WT_LATENCY - 1)) state_next = DONE;
                else drain_next = drain_reg + DW'(1);
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate rise clears phase and takes priority over the slot's own advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                freq_reg[i]  <= '0;
                phase_reg[i] <= '0;
            end
            gate_reg <= '0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (cfg_hit[i]) begin
                    freq_reg[i] <= bus.cfg_freq;
                    gate_reg[i] <= bus.cfg_gate;
                end
                if (gate_rise[i]) phase_reg[i] <= '0;
                else if (slot_hit[i] && gate_reg[i]) phase_reg[i] <= phase_reg[i] + inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid_reg <= '0;
            pipe_gate_reg  <= '0;
            for (int i = 0; i <= WT_LATENCY; i++) pipe_voice_reg[i] <= '0;
            wt_phase_reg   <= '0;
        end else begin
            pipe_valid_reg    <= {pipe_valid_reg[WT_LATENCY-1:0], slot_active};
            pipe_gate_reg     <= {pipe_gate_reg[WT_LATENCY-1:0], slot_active & gate_reg[slot_reg]};
            pipe_voice_reg[0] <= slot_reg;
            for (int i = 1; i <= WT_LATENCY; i++) pipe_voice_reg[i] <= pipe_voice_reg[i-1];
            if (slot_active) wt_phase_reg <= phase_reg[slot_reg];
        end
    end

    assign amp     = (pipe_valid_reg[WT_LATENCY] && pipe_gate_reg[WT_LATENCY]) ? bus.wt_q : '0;
    assign amp_ext = {{VW{amp[AMP_BITS-1]}}, amp};
    assign sum     = acc_reg + amp_ext;

    always_comb begin
        if (sum > ACC_MAX)      mix_sat = AMP_MAX;
        else if (sum < ACC_MIN) mix_sat = AMP_MIN;
        else                    mix_sat = sum[AMP_BITS-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            slot_reg      <= '0;
            drain_reg     <= '0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            acc_reg       <= '0;
            mix_reg       <= '0;
            mix_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            drain_reg     <= drain_next;
            busy_reg      <= (state_reg != IDLE);
            overrun_reg   <= overrun_reg | (bus.sample_tick && ((state_reg != IDLE) || busy_reg));
            mix_valid_reg <= done;
            if (accept) acc_reg <= '0;
            else if (pipe_valid_reg[WT_LATENCY]) acc_reg <= sum;
            if (done) mix_reg <= mix_sat;
        end
    end

    assign bus.wt_phase  = wt_phase_reg;
    assign bus.out_valid = pipe_valid_reg[WT_LATENCY];
    assign bus.out_voice = pipe_voice_reg[WT_LATENCY];
    assign bus.out_amp   = amp;
    assign bus.mix_valid = mix_valid_reg;
    assign bus.mix       = mix_reg;
    assign bus.busy      = busy_reg;
    assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Directed bench for nco_voice_scheduler with a stubbed 1-cycle wavetable.
module tb_nco_voice_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   stub_mode = 0;
    logic signed [15:0] stub_q_reg = 16'sd0;

    nco_voice_scheduler_if bus ();

    nco_voice_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Wavetable stand-in: 0=constant 100, 1=max, 2=min, 3=+max/-max by voice parity.
    always @(posedge clock)
        stub_q_reg <= (stub_mode == 1) ? 16'sh7fff : (stub_mode == 2) ? 16'sh8000 : 16'sd100;
    assign bus.wt_q = (stub_mode == 3) ? (bus.out_voice[0] ? -16'sd32767 : 16'sd32767) : stub_q_reg;

    logic [25:0]        cap_phase [1:12];
    logic               cap_busy  [1:12];
    logic               cap_valid [1:12];
    logic [2:0]         cap_voice [1:12];
    logic signed [15:0] cap_amp   [1:12];
    logic               cap_mv    [1:12];
    logic signed [15:0] cap_mix   [1:12];
    logic               cap_ovr   [1:12];

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] v, input logic [15:0] f, input logic g);
        @(negedge clock);
        bus.cfg_we = 1'b1; bus.cfg_voice = v; bus.cfg_freq = f; bus.cfg_gate = g;
        @(negedge clock);
        bus.cfg_we = 1'b0;
        $display("cfg voice=%0d freq=%0d gate=%0b", v, f, g);
    endtask

    // Tick at edge T, then capture outputs 1ns after edges T+1..T+12.
    task automatic sweep(input int extra, input int cfg_k, input logic [2:0] cv,
                         input logic [15:0] cf, input logic cg);
        @(negedge clock);
        bus.sample_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            bus.sample_tick = (k == extra);
            bus.cfg_we = (k == cfg_k); bus.cfg_voice = cv; bus.cfg_freq = cf; bus.cfg_gate = cg;
            @(posedge clock);
            #1;
            cap_phase[k] = bus.wt_phase;  cap_busy[k] = bus.busy;
            cap_valid[k] = bus.out_valid; cap_voice[k] = bus.out_voice;
            cap_amp[k]   = bus.out_amp;   cap_mv[k] = bus.mix_valid;
            cap_mix[k]   = bus.mix;       cap_ovr[k] = bus.overrun;
        end
        @(negedge clock);
        bus.sample_tick = 1'b0;
        bus.cfg_we = 1'b0;
        $display("sweep extra_tick=%0d cfg_at=%0d: mix_valid@10=%0b mix=%0d overrun=%0b",
                 extra, cfg_k, cap_mv[10], cap_mix[10], cap_ovr[12]);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({bus.busy, bus.overrun, bus.mix_valid, bus.out_valid} !== 4'b0 ||
            bus.wt_phase !== 26'd0 || bus.mix !== 16'sd0 || bus.out_amp !== 16'sd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b ovr=%0b mv=%0b ov=%0b phase=%0d mix=%0d amp=%0d required all 0",
                     bus.busy, bus.overrun, bus.mix_valid, bus.out_valid, bus.wt_phase, bus.mix, bus.out_amp);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.mix_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b mix_valid=%0b required 0 0", bus.busy, bus.mix_valid);
        end
    endtask

    task automatic test_idle_sweep();
        int n_busy;
        int n_valid;
        stub_mode = 0;
        sweep(0, 0, 3'd0, 16'd0, 1'b0);
        n_busy = 0;
        n_valid = 0;
        for (int k = 1; k <= 12; k++) begin
            if (cap_busy[k]) n_busy++;
            if (cap_valid[k]) n_valid++;
            if (k >= 2 && k <= 9) begin
                checks++;
                if (cap_valid[k] !== 1'b1 || cap_voice[k] !== 3'(k - 2) || cap_amp[k] !== 16'sd0) begin
                    errors++;
                    $display("FAIL idle_slot k=%0d: valid=%0b voice=%0d amp=%0d required 1 %0d 0",
                             k, cap_valid[k], cap_voice[k], cap_amp[k], k - 2);
                end
            end
            checks++;
            if (cap_mv[k] !== (k == 10)) begin
                errors++;
                $display("FAIL idle_mix_valid k=%0d: got %0b required %0b", k, cap_mv[k], (k == 10));
            end
        end
        checks++;
        if (n_busy != 10 || cap_busy[1] !== 1'b1 || cap_busy[11] !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: cycles=%0d first=%0b after=%0b required 10 1 0", n_busy, cap_busy[1], cap_busy[11]);
        end
        checks++;
        if (n_valid != 8 || cap_mix[10] !== 16'sd0 || cap_ovr[12] !== 1'b0) begin
            errors++;
            $display("FAIL idle_mix: valids=%0d mix=%0d ovr=%0b required 8 0 0", n_valid, cap_mix[10], cap_ovr[12]);
        end
    endtask

    task automatic test_gate_freq();
        logic [25:0] exp_ph [3];
        logic [25:0] want;
        exp_ph[0] = 26'd0; exp_ph[1] = 26'd153560; exp_ph[2] = 26'd307120;
        stub_mode = 0;
        cfg_write(3'd3, 16'd440, 1'b1);
        for (int s = 0; s < 3; s++) begin
            sweep(0, 0, 3'd0, 16'd0, 1'b0);
            for (int v = 0; v < 8; v++) begin
                want = (v == 3) ? exp_ph[s] : 26'd0;
                checks++;
                if (cap_phase[1 + v] !== want) begin
                    errors++;
                    $display("FAIL gate_phase sweep=%0d slot=%0d: got %0d required %0d", s, v, cap_phase[1 + v], want);
                end
            end
            checks++;
            if (cap_amp[5] !== 16'sd100 || cap_amp[4] !== 16'sd0 || cap_mix[10] !== 16'sd100) begin
                errors++;
                $display("FAIL gate_amp sweep=%0d: amp3=%0d amp2=%0d mix=%0d required 100 0 100",
                         s, cap_amp[5], cap_amp[4], cap_mix[10]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [25:0] exp_ph [4];
        exp_ph[0] = 26'd0; exp_ph[1] = 26'd22871715; exp_ph[2] = 26'd45743430; exp_ph[3] = 26'd1506281;
        do_reset();
        cfg_write(3'd0, 16'd65535, 1'b1);
        for (int s = 0; s < 4; s++) begin
            sweep(0, 0, 3'd0, 16'd0, 1'b0);
            checks++;
            if (cap_phase[1] !== exp_ph[s] || cap_ovr[12] !== 1'b0) begin
                errors++;
                $display("FAIL wrap_phase sweep=%0d: phase=%0d ovr=%0b required %0d 0", s, cap_phase[1], cap_ovr[12], exp_ph[s]);
            end
        end
    endtask

    task automatic test_saturation();
        int modes [4];
        logic signed [15:0] exp_mix [4];
        modes[0] = 1; modes[1] = 0; modes[2] = 2; modes[3] = 3;
        exp_mix[0] = 16'sh7fff; exp_mix[1] = 16'sd800; exp_mix[2] = 16'sh8000; exp_mix[3] = 16'sd0;
        do_reset();
        for (int v = 0; v < 8; v++) cfg_write(3'(v), 16'd0, 1'b1);
        for (int m = 0; m < 4; m++) begin
            stub_mode = modes[m];
            sweep(0, 0, 3'd0, 16'd0, 1'b0);
            checks++;
            if (cap_mv[10] !== 1'b1 || cap_mix[10] !== exp_mix[m]) begin
                errors++;
                $display("FAIL sat_mix mode=%0d: mv=%0b mix=%0d required 1 %0d", modes[m], cap_mv[10], cap_mix[10], exp_mix[m]);
            end
        end
        stub_mode = 0;
    endtask

    task automatic test_overrun();
        int n_valid;
        do_reset();
        sweep(4, 0, 3'd0, 16'd0, 1'b0);
        n_valid = 0;
        for (int k = 1; k <= 12; k++) if (cap_valid[k]) n_valid++;
        checks++;
        if (cap_ovr[4] !== 1'b1 || cap_ovr[3] !== 1'b0 || cap_mv[10] !== 1'b1 || n_valid != 8 || cap_busy[12] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_mid: ovr3=%0b ovr4=%0b mv=%0b valids=%0d busy12=%0b required 0 1 1 8 0",
                     cap_ovr[3], cap_ovr[4], cap_mv[10], n_valid, cap_busy[12]);
        end
        sweep(0, 0, 3'd0, 16'd0, 1'b0);
        checks++;
        if (cap_busy[1] !== 1'b1 || cap_mv[10] !== 1'b1 || cap_ovr[12] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_next: busy1=%0b mv=%0b ovr=%0b required 1 1 1", cap_busy[1], cap_mv[10], cap_ovr[12]);
        end
        do_reset();
        sweep(11, 0, 3'd0, 16'd0, 1'b0);
        checks++;
        if (cap_ovr[10] !== 1'b0 || cap_ovr[11] !== 1'b1 || cap_busy[12] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_at_mix: ovr10=%0b ovr11=%0b busy12=%0b required 0 1 0", cap_ovr[10], cap_ovr[11], cap_busy[12]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bad_mv;
        do_reset();
        stub_mode = 0;
        cfg_write(3'd2, 16'd1000, 1'b1);
        sweep(0, 3, 3'd2, 16'd2000, 1'b1);
        sweep(0, 0, 3'd0, 16'd0, 1'b0);
        checks++;
        if (cap_phase[3] !== 26'd349000) begin
            errors++;
            $display("FAIL slot_cfg_old_freq: phase=%0d required 349000", cap_phase[3]);
        end
        sweep(0, 0, 3'd0, 16'd0, 1'b0);
        checks++;
        if (cap_phase[3] !== 26'd1047000 || cap_mix[10] !== 16'sd100) begin
            errors++;
            $display("FAIL slot_cfg_new_freq: phase=%0d mix=%0d required 1047000 100", cap_phase[3], cap_mix[10]);
        end
        @(negedge clock);
        bus.sample_tick = 1'b1;
        @(negedge clock);
        bus.sample_tick = 1'b0;
        repeat (4) @(posedge clock);
        @(posedge clock);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: busy=%0b required 1", bus.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.overrun, bus.mix_valid, bus.out_valid} !== 4'b0 ||
            bus.wt_phase !== 26'd0 || bus.mix !== 16'sd0 || bus.out_amp !== 16'sd0) begin
            errors++;
            $display("FAIL midreset_async: busy=%0b ovr=%0b mv=%0b ov=%0b phase=%0d mix=%0d amp=%0d required all 0",
                     bus.busy, bus.overrun, bus.mix_valid, bus.out_valid, bus.wt_phase, bus.mix, bus.out_amp);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        bad_mv = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            #1;
            if (bus.mix_valid !== 1'b0 || bus.busy !== 1'b0) bad_mv++;
        end
        checks++;
        if (bad_mv != 0) begin
            errors++;
            $display("FAIL midreset_no_mix: active cycles=%0d required 0", bad_mv);
        end
        sweep(0, 0, 3'd0, 16'd0, 1'b0);
        checks++;
        if (cap_phase[3] !== 26'd0 || cap_amp[4] !== 16'sd0 || cap_mix[10] !== 16'sd0) begin
            errors++;
            $display("FAIL midreset_state: phase2=%0d amp2=%0d mix=%0d required 0 0 0", cap_phase[3], cap_amp[4], cap_mix[10]);
        end
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_voice   = 3'd0;
        bus.cfg_freq    = 16'd0;
        bus.cfg_gate    = 1'b0;
        test_reset();
        test_idle_sweep();
        test_gate_freq();
        test_wrap();
        test_saturation();
        test_overrun();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
